page_table_walker: RTL and testbench

Hardware Sv32 page-table walker that refills the instruction and data TLBs on a miss. It arbitrates between the two TLBs' miss requests, walks the two-level page table through a single-outstanding memory port, optionally updates PTE A/D bits, and writes the resulting TlbEntry, valid or faulting, into the requesting TLB. It sits between the fetch/load-store TLBs and the memory arbiter, beside the CSR unit.

---
 rtl/page_table_walker_pkg.sv | 104 ++++++++++
 rtl/page_table_walker_arbiter.sv | 28 ++
 rtl/page_table_walker.sv | 221 ++++++++++++++++++++++
 tb/tb_page_table_walker.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_table_walker_pkg.sv
// Shared types for the Sv32 page-table walker: PTE and TLB entry layouts, walker states and PTE classification helpers.
package page_table_walker_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned VPN_WIDTH     = 20;
  localparam int unsigned PPN_WIDTH     = 22;
  localparam int unsigned PADDR_WIDTH   = 34;
  localparam int unsigned PTE_SIZE_LOG2 = 2;

  typedef logic [VPN_WIDTH-1:0] virtual_page_number_t;

  typedef enum logic [1:0] {
    Instruction = 2'd0,
    Load        = 2'd1,
    Store       = 2'd2
  } MemoryAccessType;

  typedef struct packed {
    logic                 mode;
    logic [8:0]           asid;
    logic [PPN_WIDTH-1:0] ppn;
  } csr_satp_t;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } PageTableEntry;

  typedef struct packed {
    logic [PPN_WIDTH-1:0] pageNumber;
    logic                 dirty;
    logic                 accessed;
    logic                 isGlobal;
    logic                 user;
    logic                 execute;
    logic                 writable;
    logic                 readable;
    logic                 fault;
    logic                 valid;
  } TlbEntry;

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    ReadL1    = 3'd1,
    ReadL0    = 3'd2,
    WriteBack = 3'd3,
    Fill      = 3'd4
  } PtwState;

  function automatic logic pteInvalid(input PageTableEntry p);
    return !p.v || (!p.r && p.w);
  endfunction

  function automatic logic pteLeaf(input PageTableEntry p);
    return p.r || p.x;
  endfunction

  function automatic logic needsAd(input PageTableEntry p, input MemoryAccessType t);
    return !p.a || ((t == Store) && !p.d);
  endfunction

  function automatic PageTableEntry setAd(input PageTableEntry p, input MemoryAccessType t);
    PageTableEntry q;
    q   = p;
    q.a = 1'b1;
    if (t == Store) q.d = 1'b1;
    return q;
  endfunction

  // Superpages take the low page-number bits from the VPN.
  function automatic TlbEntry makeEntry(input PageTableEntry p, input logic [9:0] vpn0,
                                        input logic superpage);
    TlbEntry e;
    e            = '0;
    e.valid      = 1'b1;
    e.pageNumber = superpage ? {p.ppn1, vpn0} : {p.ppn1, p.ppn0};
    e.dirty      = p.d;
    e.accessed   = p.a;
    e.isGlobal   = p.g;
    e.user       = p.u;
    e.execute    = p.x;
    e.writable   = p.w;
    e.readable   = p.r;
    return e;
  endfunction

  function automatic TlbEntry faultEntry();
    TlbEntry e;
    e       = '0;
    e.valid = 1'b1;
    e.fault = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/page_table_walker_arbiter.sv
// PtwArbiter: two-way round-robin between ITLB and DTLB misses; the side granted last loses a tie.
module PtwArbiter (
  input  logic clk,
  input  logic rst,
  input  logic reqI,
  input  logic reqD,
  input  logic take,
  output logic grantValid_c,
  output logic grantSel_c
);

  logic lastWasD;

  always_comb begin
    grantValid_c = reqI | reqD;
    grantSel_c   = (reqI && reqD) ? !lastWasD : reqD;
  end

  // Reset value makes the D side win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastWasD <= 1'b0;
    end else if (take) begin
      lastWasD <= grantSel_c;
    end
  end

endmodule

// File: rtl/page_table_walker.sv
// Sv32 page-table walker refilling the ITLB/DTLB. Define RAFI_PTW_AD_UPDATE_EN to write back PTE A/D bits;
// otherwise an A/D requirement yields a fault entry.
module page_table_walker
  import page_table_walker_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   itlbReq,
  input  logic                   dtlbReq,
  input  virtual_page_number_t   itlbVpn,
  input  virtual_page_number_t   dtlbVpn,
  input  MemoryAccessType        dtlbAccessType,
  output logic                   itlbDone,
  output logic                   dtlbDone,
  output logic                   tlbWriteEnable,
  output logic                   tlbWriteSelect,
  output virtual_page_number_t   tlbWriteKey,
  output TlbEntry                tlbWriteValue,
  output logic [PADDR_WIDTH-1:0] memAddr,
  output logic                   memReadEnable,
  output logic                   memWriteEnable,
  output logic [XLEN-1:0]        memWriteValue,
  input  logic [XLEN-1:0]        memReadValue,
  input  logic                   memDone,
  input  csr_satp_t              csrSatp,
  input  logic                   flush
);

  PtwState              state, stateNext;
  virtual_page_number_t walkVpn, walkVpnNext, grantVpn;
  MemoryAccessType      walkType, walkTypeNext;
  logic                 walkSel, walkSelNext;
  PageTableEntry        walkPte, walkPteNext, fetchedPte;
  logic                 walkSuper, walkSuperNext;
  logic                 stale, staleNext;

  logic [PADDR_WIDTH-1:0] memAddrNext;
  logic                   memReadEnableNext, memWriteEnableNext;
  logic [XLEN-1:0]        memWriteValueNext;
  logic                   tlbWriteEnableNext, tlbWriteSelectNext;
  virtual_page_number_t   tlbWriteKeyNext;
  TlbEntry                tlbWriteValueNext, fillEntry;
  logic                   itlbDoneNext, dtlbDoneNext;

  logic arbTake, grantValid_c, grantSel_c;
  logic leafHit, leafSuper, doFill;
  logic unusedBits;

  PtwArbiter arbiter (
    .clk         (clk),
    .rst         (rst),
    .reqI        (itlbReq),
    .reqD        (dtlbReq),
    .take        (arbTake),
    .grantValid_c(grantValid_c),
    .grantSel_c  (grantSel_c)
  );

  // Next-state, memory request and fill generation.
  always_comb begin
    stateNext          = state;
    walkVpnNext        = walkVpn;
    walkTypeNext       = walkType;
    walkSelNext        = walkSel;
    walkPteNext        = walkPte;
    walkSuperNext      = walkSuper;
    staleNext          = (state == Idle) ? 1'b0 : (stale | flush);
    memAddrNext        = '0;
    memReadEnableNext  = 1'b0;
    memWriteEnableNext = 1'b0;
    memWriteValueNext  = '0;
    tlbWriteEnableNext = 1'b0;
    tlbWriteSelectNext = 1'b0;
    tlbWriteKeyNext    = '0;
    tlbWriteValueNext  = '0;
    itlbDoneNext       = 1'b0;
    dtlbDoneNext       = 1'b0;
    arbTake            = 1'b0;
    grantVpn           = grantSel_c ? dtlbVpn : itlbVpn;
    fetchedPte         = PageTableEntry'(memReadValue);
    leafHit            = 1'b0;
    leafSuper          = 1'b0;
    doFill             = 1'b0;
    fillEntry          = faultEntry();

    unique case (state)
      Idle: begin
        if (grantValid_c) begin
          arbTake           = 1'b1;
          walkSelNext       = grantSel_c;
          walkVpnNext       = grantVpn;
          walkTypeNext      = grantSel_c ? dtlbAccessType : Instruction;
          memReadEnableNext = 1'b1;
          memAddrNext       = {csrSatp.ppn, grantVpn[19:10], {PTE_SIZE_LOG2{1'b0}}};
          stateNext         = ReadL1;
        end
      end
      ReadL1: begin
        if (!memDone) begin
          memReadEnableNext = 1'b1;
          memAddrNext       = memAddr;
        end else begin
          walkPteNext = fetchedPte;
          if (pteInvalid(fetchedPte)) begin
            doFill = 1'b1;
          end else if (pteLeaf(fetchedPte)) begin
            leafHit   = 1'b1;
            leafSuper = 1'b1;
          end else begin
            memReadEnableNext = 1'b1;
            memAddrNext = {fetchedPte.ppn1, fetchedPte.ppn0, walkVpn[9:0], {PTE_SIZE_LOG2{1'b0}}};
            stateNext   = ReadL0;
          end
        end
      end
      ReadL0: begin
        if (!memDone) begin
          memReadEnableNext = 1'b1;
          memAddrNext       = memAddr;
        end else begin
          walkPteNext = fetchedPte;
          if (pteInvalid(fetchedPte) || !pteLeaf(fetchedPte)) doFill = 1'b1;
          else leafHit = 1'b1;
        end
      end
`ifdef RAFI_PTW_AD_UPDATE_EN
      WriteBack: begin
        if (!memDone) begin
          memWriteEnableNext = 1'b1;
          memAddrNext        = memAddr;
          memWriteValueNext  = memWriteValue;
        end else begin
          doFill    = 1'b1;
          fillEntry = makeEntry(walkPte, walkVpn[9:0], walkSuper);
        end
      end
`endif
      Fill:    stateNext = Idle;
      default: stateNext = Idle;
    endcase

    // Leaf handling shared by both levels; the PTE address is still on memAddr for write-back.
    if (leafHit) begin
      walkSuperNext = leafSuper;
      if (leafSuper && (fetchedPte.ppn0 != '0)) begin
        doFill = 1'b1;
      end else if (needsAd(fetchedPte, walkType)) begin
`ifdef RAFI_PTW_AD_UPDATE_EN
        walkPteNext        = setAd(fetchedPte, walkType);
        memWriteEnableNext = 1'b1;
        memAddrNext        = memAddr;
        memWriteValueNext  = XLEN'(setAd(fetchedPte, walkType));
        stateNext          = WriteBack;
`else
        doFill = 1'b1;
`endif
      end else begin
        doFill    = 1'b1;
        fillEntry = makeEntry(fetchedPte, walkVpn[9:0], leafSuper);
      end
    end

    // A flushed walk still completes so the requester retries, but must not install its entry.
    if (doFill) begin
      stateNext          = Fill;
      tlbWriteEnableNext = !(stale || flush);
      tlbWriteSelectNext = walkSel;
      tlbWriteKeyNext    = walkVpn;
      tlbWriteValueNext  = fillEntry;
      itlbDoneNext       = !walkSel;
      dtlbDoneNext       = walkSel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= Idle;
      walkVpn        <= '0;
      walkType       <= Instruction;
      walkSel        <= 1'b0;
      walkPte        <= '0;
      walkSuper      <= 1'b0;
      stale          <= 1'b0;
      memAddr        <= '0;
      memReadEnable  <= 1'b0;
      memWriteEnable <= 1'b0;
      memWriteValue  <= '0;
      tlbWriteEnable <= 1'b0;
      tlbWriteSelect <= 1'b0;
      tlbWriteKey    <= '0;
      tlbWriteValue  <= '0;
      itlbDone       <= 1'b0;
      dtlbDone       <= 1'b0;
    end else begin
      state          <= stateNext;
      walkVpn        <= walkVpnNext;
      walkType       <= walkTypeNext;
      walkSel        <= walkSelNext;
      walkPte        <= walkPteNext;
      walkSuper      <= walkSuperNext;
      stale          <= staleNext;
      memAddr        <= memAddrNext;
      memReadEnable  <= memReadEnableNext;
      memWriteEnable <= memWriteEnableNext;
      memWriteValue  <= memWriteValueNext;
      tlbWriteEnable <= tlbWriteEnableNext;
      tlbWriteSelect <= tlbWriteSelectNext;
      tlbWriteKey    <= tlbWriteKeyNext;
      tlbWriteValue  <= tlbWriteValueNext;
      itlbDone       <= itlbDoneNext;
      dtlbDone       <= dtlbDoneNext;
    end
  end

`ifdef RAFI_PTW_AD_UPDATE_EN
  assign unusedBits = ^{csrSatp.mode, csrSatp.asid, walkPte.rsw, fetchedPte.rsw};
`else
  assign unusedBits = ^{csrSatp.mode, csrSatp.asid, walkPte, walkSuper, fetchedPte.rsw};
`endif

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: vector table of walks against a zero-wait PTE memory plus
// hand sequences for arbitration, flush and mid-walk reset.
module tb_page_table_walker;
  import page_table_walker_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   itlbReq, dtlbReq;
  virtual_page_number_t   itlbVpn, dtlbVpn;
  MemoryAccessType        dtlbAccessType;
  logic                   itlbDone, dtlbDone;
  logic                   tlbWriteEnable, tlbWriteSelect;
  virtual_page_number_t   tlbWriteKey;
  TlbEntry                tlbWriteValue;
  logic [PADDR_WIDTH-1:0] memAddr;
  logic                   memReadEnable, memWriteEnable;
  logic [XLEN-1:0]        memWriteValue, memReadValue;
  logic                   memDone;
  csr_satp_t              csrSatp;
  logic                   flush;

  page_table_walker dut (
    .clk(clk), .rst(rst),
    .itlbReq(itlbReq), .dtlbReq(dtlbReq),
    .itlbVpn(itlbVpn), .dtlbVpn(dtlbVpn),
    .dtlbAccessType(dtlbAccessType),
    .itlbDone(itlbDone), .dtlbDone(dtlbDone),
    .tlbWriteEnable(tlbWriteEnable), .tlbWriteSelect(tlbWriteSelect),
    .tlbWriteKey(tlbWriteKey), .tlbWriteValue(tlbWriteValue),
    .memAddr(memAddr), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memWriteValue(memWriteValue), .memReadValue(memReadValue), .memDone(memDone),
    .csrSatp(csrSatp), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Zero-wait PTE memory, active only when memAuto is set.
  logic [31:0] mem [logic [33:0]];
  logic        memAuto = 1'b0;
  int          readCount = 0, writeCount = 0;
  logic [33:0] readAddr [4];
  logic [33:0] lastWriteAddr;
  logic [31:0] lastWriteValue;

  always @(negedge clk) begin
    if (memAuto) begin
      memDone = 1'b0;
      if (memReadEnable) begin
        memDone      = 1'b1;
        memReadValue = mem.exists(memAddr) ? mem[memAddr] : 32'h0;
        if (readCount < 4) readAddr[readCount] = memAddr;
        readCount++;
      end else if (memWriteEnable) begin
        memDone        = 1'b1;
        mem[memAddr]   = memWriteValue;
        lastWriteAddr  = memAddr;
        lastWriteValue = memWriteValue;
        writeCount++;
      end
    end
  end

  typedef struct {
    logic            isD;
    logic [19:0]     vpn;
    MemoryAccessType acc;
    logic [33:0]     l1Addr;
    logic [31:0]     l1Pte;
    logic [33:0]     l0Addr;
    logic [31:0]     l0Pte;
    int              expReads;
    int              expWrites;
    logic [33:0]     expWAddr;
    logic [31:0]     expWVal;
    logic            expFault;
    logic [21:0]     expPage;
    logic            expDirty;
    int              expCycles;
  } vec_t;

  function automatic vec_t mkVec(input logic isD, input logic [19:0] vpn, input MemoryAccessType acc,
                                 input logic [33:0] l1Addr, input logic [31:0] l1Pte,
                                 input logic [33:0] l0Addr, input logic [31:0] l0Pte,
                                 input int reads, input int writes, input logic [33:0] wAddr,
                                 input logic [31:0] wVal, input logic fault, input logic [21:0] page,
                                 input logic dirty, input int cycles);
    vec_t v;
    v.isD = isD; v.vpn = vpn; v.acc = acc;
    v.l1Addr = l1Addr; v.l1Pte = l1Pte; v.l0Addr = l0Addr; v.l0Pte = l0Pte;
    v.expReads = reads; v.expWrites = writes; v.expWAddr = wAddr; v.expWVal = wVal;
    v.expFault = fault; v.expPage = page; v.expDirty = dirty; v.expCycles = cycles;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic waitDone(output int cycles, output logic gotI, output logic gotD, output logic sawWe,
                          output TlbEntry we, output logic weSel, output logic [19:0] weKey);
    cycles = 0; gotI = 1'b0; gotD = 1'b0; sawWe = 1'b0; we = '0; weSel = 1'b0; weKey = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      cycles++;
      if (tlbWriteEnable) begin
        sawWe = 1'b1; we = tlbWriteValue; weSel = tlbWriteSelect; weKey = tlbWriteKey;
      end
      if (itlbDone || dtlbDone) begin
        gotI = itlbDone; gotD = dtlbDone;
        break;
      end
    end
  endtask

  task automatic flushRun(input string name, input logic isD, input logic [19:0] vpn,
                          input MemoryAccessType acc, input logic [33:0] trig);
    logic hit, gotI, gotD, sawWe;
    hit = 1'b0; gotI = 1'b0; gotD = 1'b0; sawWe = 1'b0;
    readCount = 0;
    @(negedge clk);
    if (isD) begin dtlbReq = 1'b1; dtlbVpn = vpn; dtlbAccessType = acc; end
    else begin itlbReq = 1'b1; itlbVpn = vpn; end
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (memReadEnable && memAddr == trig) begin hit = 1'b1; flush = 1'b1; end
    end
    check({name, " trigger"}, hit, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (tlbWriteEnable) sawWe = 1'b1;
      if (itlbDone || dtlbDone) begin gotI = itlbDone; gotD = dtlbDone; break; end
    end
    itlbReq = 1'b0; dtlbReq = 1'b0;
    check({name, " done"}, {gotI, gotD}, {!isD, isD});
    check({name, " no write"}, sawWe, 1'b0);
    check({name, " reads"}, 64'(readCount), 64'd2);
  endtask

  initial begin
    int       cyc;
    logic     gotI, gotD, sawWe, weSel, bad;
    TlbEntry  we;
    logic [19:0] weKey;
    vec_t     v;
    string    n;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        gotI, gotD, sawWe, weSel, bad, expD;
    TlbEntry     we;
    logic [19:0] weKey;
    vec_t        v;
    string       n;

    rst = 1'b1; itlbReq = 1'b0; dtlbReq = 1'b0; itlbVpn = '0; dtlbVpn = '0;
    dtlbAccessType = Load; memReadValue = '0; memDone = 1'b0; flush = 1'b0;
    csrSatp = '0; csrSatp.ppn = 22'h80000;

    vecs[0] = mkVec(1'b0, 20'h12345, Instruction, 34'h080000120, 32'h20004001, 34'h080010D14,
                    32'h02AF34CF, 2, 0, '0, '0, 1'b0, 22'h0ABCD, 1'b1, 3);
    vecs[1] = mkVec(1'b1, 20'h00400, Load, 34'h080000004, 32'h001004CF, '0, '0,
                    1, 0, '0, '0, 1'b1, '0, 1'b0, 2);
    vecs[2] = mkVec(1'b1, 20'h00C05, Load, 34'h08000000C, 32'h002000CF, '0, '0,
                    1, 0, '0, '0, 1'b0, 22'h00805, 1'b1, 2);
    vecs[3] = mkVec(1'b0, 20'h01000, Instruction, 34'h080000010, 32'h00000000, '0, '0,
                    1, 0, '0, '0, 1'b1, '0, 1'b0, 2);
    vecs[4] = mkVec(1'b0, 20'h01400, Instruction, 34'h080000014, 32'h00000005, '0, '0,
                    1, 0, '0, '0, 1'b1, '0, 1'b0, 2);
    vecs[5] = mkVec(1'b1, 20'h01801, Load, 34'h080000018, 32'h20008001, 34'h080020004,
                    32'h00000001, 2, 0, '0, '0, 1'b1, '0, 1'b0, 3);
`ifdef RAFI_PTW_AD_UPDATE_EN
    vecs[6] = mkVec(1'b1, 20'h01C02, Store, 34'h08000001C, 32'h2000C001, 34'h080030008,
                    32'h048D1447, 2, 1, 34'h080030008, 32'h048D14C7, 1'b0, 22'h12345, 1'b1, 4);
    vecs[8] = mkVec(1'b0, 20'h02404, Instruction, 34'h080000024, 32'h0030000B, '0, '0,
                    1, 1, 34'h080000024, 32'h0030004B, 1'b0, 22'h00C04, 1'b0, 3);
`else
    vecs[6] = mkVec(1'b1, 20'h01C02, Store, 34'h08000001C, 32'h2000C001, 34'h080030008,
                    32'h048D1447, 2, 0, '0, '0, 1'b1, '0, 1'b0, 3);
    vecs[8] = mkVec(1'b0, 20'h02404, Instruction, 34'h080000024, 32'h0030000B, '0, '0,
                    1, 0, '0, '0, 1'b1, '0, 1'b0, 2);
`endif
    vecs[7] = mkVec(1'b1, 20'h02003, Load, 34'h080000020, 32'h20010001, 34'h08004000C,
                    32'h001DDC43, 2, 0, '0, '0, 1'b0, 22'h00777, 1'b0, 3);

    for (int i = 0; i < NV; i++) begin
      mem[vecs[i].l1Addr] = vecs[i].l1Pte;
      if (vecs[i].expReads > 1) mem[vecs[i].l0Addr] = vecs[i].l0Pte;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset memReadEnable", memReadEnable, 1'b0);
    check("reset memWriteEnable", memWriteEnable, 1'b0);
    check("reset memAddr", memAddr, '0);
    check("reset tlbWriteEnable", tlbWriteEnable, 1'b0);
    check("reset done", {itlbDone, dtlbDone}, 2'b00);
    check("reset tlbWriteValue", tlbWriteValue, '0);

    // memDone while idle must not start anything.
    memDone = 1'b1; memReadValue = 32'hFFFFFFFF;
    @(negedge clk);
    memDone = 1'b0;
    @(negedge clk);
    check("idle memDone ignored", {memReadEnable, tlbWriteEnable, itlbDone, dtlbDone}, 4'b0);
    memAuto = 1'b1;

    // Simultaneous requests from reset: D wins first, then alternation.
    itlbVpn = 20'h00C05; dtlbVpn = 20'h00C05; dtlbAccessType = Load;
    itlbReq = 1'b1; dtlbReq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitDone(cyc, gotI, gotD, sawWe, we, weSel, weKey);
      expD = (k % 2 == 0);
      check($sformatf("rr grant %0d", k), {gotI, gotD}, {!expD, expD});
    end
    itlbReq = 1'b0; dtlbReq = 1'b0;

    // Flush during the L0 read and during the L1 read (stale bit).
    flushRun("flush L0", 1'b1, 20'h02003, Load, 34'h08004000C);
    flushRun("flush L1", 1'b0, 20'h12345, Instruction, 34'h080000120);

    // Table of walks.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      readCount = 0; writeCount = 0;
      @(negedge clk);
      if (v.isD) begin dtlbReq = 1'b1; dtlbVpn = v.vpn; dtlbAccessType = v.acc; end
      else begin itlbReq = 1'b1; itlbVpn = v.vpn; end
      waitDone(cyc, gotI, gotD, sawWe, we, weSel, weKey);
      itlbReq = 1'b0; dtlbReq = 1'b0;
      n = $sformatf("v%0d", i);
      check({n, " done side"}, {gotI, gotD}, {!v.isD, v.isD});
      check({n, " cycles"}, 64'(cyc), 64'(v.expCycles));
      check({n, " write enable"}, sawWe, 1'b1);
      check({n, " select"}, weSel, v.isD);
      check({n, " key"}, weKey, v.vpn);
      check({n, " valid"}, we.valid, 1'b1);
      check({n, " fault"}, we.fault, v.expFault);
      if (!v.expFault) begin
        check({n, " pageNumber"}, we.pageNumber, v.expPage);
        check({n, " dirty"}, we.dirty, v.expDirty);
      end
      check({n, " reads"}, 64'(readCount), 64'(v.expReads));
      check({n, " L1 addr"}, readAddr[0], v.l1Addr);
      if (v.expReads > 1) check({n, " L0 addr"}, readAddr[1], v.l0Addr);
      check({n, " writes"}, 64'(writeCount), 64'(v.expWrites));
      if (v.expWrites > 0) begin
        check({n, " write addr"}, lastWriteAddr, v.expWAddr);
        check({n, " write value"}, lastWriteValue, v.expWVal);
      end
    end

    // Reset in ReadL0 with memDone pending: back to Idle, outputs zero, no done.
    @(negedge clk);
    memAuto = 1'b0; memDone = 1'b0;
    itlbVpn = 20'h12345; itlbReq = 1'b1;
    bad = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (memReadEnable) begin bad = 1'b0; break; end
    end
    check("rst walk started", bad, 1'b0);
    memDone = 1'b1; memReadValue = 32'h20004001;
    @(negedge clk);
    check("rst in ReadL0", {memReadEnable, memAddr}, {1'b1, 34'h080010D14});
    rst = 1'b1; memReadValue = 32'h02AF34CF; itlbReq = 1'b0;
    @(negedge clk);
    rst = 1'b0; memDone = 1'b0;
    check("rst outputs zero", {memReadEnable, memWriteEnable, memAddr, tlbWriteEnable, itlbDone, dtlbDone},
          '0);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (itlbDone || dtlbDone || tlbWriteEnable || memReadEnable) bad = 1'b1;
    end
    check("rst no done", bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
